serializador_tramas: RTL and testbench

- Parametrised successor to the fixed 64-bit strobe-collector / serial-forwarder.
- Collects FRAME_BITS serial bits, one per rising edge of DI_STROBE, into a collection register.
- Hands each complete frame to a separate output shift register, then clocks it out on DO with a companion bit clock CLKimpr.
- Runs entirely on CLK using a clock-enable tick (no derived clocks). Adds double buffering, selectable bit order, busy/done status and sticky overflow detection.

---
 rtl/serializador_tramas.sv | 211 +++++++++++++++++++++
 tb/tb_serializador_tramas.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serializador_tramas.sv
// serializador_tramas: collects FRAME_BITS serial bits (one per DI_STROBE
// rising edge) and retransmits each frame on DO with the bit clock CLKimpr.
// Everything runs on CLK. The output bit timing comes from a clock-enable
// tick. A held collector frame gives double buffering. An edge that
// arrives while a frame is still held is lost, and this sets the sticky
// overflow flag.
module serializador_tramas #(
    parameter int FRAME_BITS = 64,
    parameter int DIV        = 125,
    parameter int FIFO_ORDER = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic DI,
    input  logic DI_STROBE,
    output logic DO,
    output logic CLKimpr,
    output logic busy,
    output logic frame_done,
    output logic overflow
);

    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam int BW = $clog2(FRAME_BITS);
    localparam int TW = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(FRAME_BITS - 1);
    localparam logic [TW-1:0] TICK_MAX  = TW'(DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    // Handshake: a bit is offered by a 0->1 transition of DI_STROBE, with DI
    // valid in that same CLK cycle. There is no ready or backpressure. While
    // a complete frame waits for the transmitter, offered bits are dropped
    // and flagged on overflow.

    logic                  strobe_prev_q;
    logic [FRAME_BITS-1:0] coll_q, coll_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  pending_q, pending_d;
    logic                  overflow_q, overflow_d;

    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bits_left_q, bits_left_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [1:0]            state_q, state_d;
    logic                  do_q, do_d;
    logic                  clk_q, clk_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  edge_det;
    logic                  tick;
    logic                  tx_finish;
    logic                  tx_free;
    logic                  load;
    logic [FRAME_BITS-1:0] load_data;
    logic [FRAME_BITS-1:0] coll_shift;

    assign edge_det   = DI_STROBE & ~strobe_prev_q;
    assign tick       = busy_q && (tick_cnt_q == TICK_MAX);
    assign tx_finish  = (state_q == S_HIGH) && tick && (bits_left_q == '0);
    assign tx_free    = !busy_q || tx_finish;
    assign coll_shift = {DI, coll_q[FRAME_BITS-1:1]};

    // Collector: accept bits, complete frames, hold a frame while TX is busy.
    always_comb begin
        coll_d     = coll_q;
        count_d    = count_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        load       = 1'b0;
        load_data  = coll_q;
        if (pending_q) begin
            if (tx_finish) begin
                // Held frame goes out now. A coincident edge starts the next frame.
                load      = 1'b1;
                load_data = coll_q;
                pending_d = 1'b0;
                count_d   = '0;
                if (edge_det) begin
                    coll_d  = coll_shift;
                    count_d = CW'(1);
                end
            end else if (edge_det) begin
                overflow_d = 1'b1;
            end
        end else if (edge_det) begin
            coll_d = coll_shift;
            if (count_q == CNT_LAST) begin
                if (tx_free) begin
                    load      = 1'b1;
                    load_data = coll_shift;
                    count_d   = '0;
                end else begin
                    pending_d = 1'b1;
                    count_d   = count_q + CW'(1);
                end
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Transmitter: tick counter plus IDLE / LOW_HALF / HIGH_HALF bit sequencing.
    always_comb begin
        shreg_d     = shreg_q;
        bits_left_d = bits_left_q;
        state_d     = state_q;
        do_d        = do_q;
        clk_d       = clk_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tick_cnt_d  = '0;
        if (busy_q && !tick) begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end
        case (state_q)
            S_LOW: begin
                if (tick) begin
                    clk_d   = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    clk_d = 1'b0;
                    if (bits_left_q == '0) begin
                        do_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        if (FIFO_ORDER != 0) begin
                            do_d    = shreg_q[0];
                            shreg_d = shreg_q >> 1;
                        end else begin
                            do_d    = shreg_q[FRAME_BITS-1];
                            shreg_d = shreg_q << 1;
                        end
                        bits_left_d = bits_left_q - BW'(1);
                        state_d     = S_LOW;
                    end
                end
            end
            default: begin
                clk_d   = 1'b0;
                do_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        // A load wins over the finishing transition. frame_done still pulses.
        if (load) begin
            if (FIFO_ORDER != 0) begin
                do_d    = load_data[0];
                shreg_d = load_data >> 1;
            end else begin
                do_d    = load_data[FRAME_BITS-1];
                shreg_d = load_data << 1;
            end
            bits_left_d = BITS_LAST;
            tick_cnt_d  = '0;
            busy_d      = 1'b1;
            clk_d       = 1'b0;
            state_d     = S_LOW;
        end
    end

    // State registers. Strobe history resets high so a held strobe is not an edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            strobe_prev_q <= 1'b1;
            coll_q        <= '0;
            count_q       <= '0;
            pending_q     <= 1'b0;
            overflow_q    <= 1'b0;
            shreg_q       <= '0;
            bits_left_q   <= '0;
            tick_cnt_q    <= '0;
            state_q       <= S_IDLE;
            do_q          <= 1'b0;
            clk_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            strobe_prev_q <= DI_STROBE;
            coll_q        <= coll_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            shreg_q       <= shreg_d;
            bits_left_q   <= bits_left_d;
            tick_cnt_q    <= tick_cnt_d;
            state_q       <= state_d;
            do_q          <= do_d;
            clk_q         <= clk_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign DO         = do_q;
    assign CLKimpr    = clk_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serializador_tramas.sv
// Directed bench for serializador_tramas with FRAME_BITS=8 and DIV=4.
// Two instances share the same stimulus: dut_a with FIFO_ORDER=1 and dut_b
// with FIFO_ORDER=0. Inputs are driven on the falling edge and outputs are
// sampled there too. k counts falling edges after the load edge.
module tb_serializador_tramas;

    logic clk = 1'b0;
    logic rst;
    logic di;
    logic di_strobe;
    logic do_a, clk_a, busy_a, done_a, ovf_a;
    logic do_b, clk_b, busy_b, done_b, ovf_b;

    int tests_run    = 0;
    int tests_failed = 0;

    // Clock
    always #5 clk = ~clk;

    serializador_tramas #(.FRAME_BITS(8), .DIV(4), .FIFO_ORDER(1)) dut_a (
        .CLK(clk), .RST(rst), .DI(di), .DI_STROBE(di_strobe),
        .DO(do_a), .CLKimpr(clk_a), .busy(busy_a),
        .frame_done(done_a), .overflow(ovf_a)
    );

    serializador_tramas #(.FRAME_BITS(8), .DIV(4), .FIFO_ORDER(0)) dut_b (
        .CLK(clk), .RST(rst), .DI(di), .DI_STROBE(di_strobe),
        .DO(do_b), .CLKimpr(clk_b), .busy(busy_b),
        .frame_done(done_b), .overflow(ovf_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One strobe pulse: high for one cycle. The task returns on the next
    // falling edge with the strobe low again.
    task automatic send_bit(input logic b);
        @(negedge clk);
        di        = b;
        di_strobe = 1'b1;
        @(negedge clk);
        di_strobe = 1'b0;
    endtask

    // Send frame f1 (bit i = i-th collected bit) so that it loads into an
    // idle transmitter, then follow it cycle by cycle. If s0 >= 0, the eight
    // bits of f2 are strobed at k = s0, s0+2, ... . After them come `extra`
    // strobes with DI=0, which arrive while f2 is still held.
    task automatic run_frames(input logic [7:0] f1, input logic [7:0] f2,
                              input int s0, input int extra, input string name);
        logic [7:0] fa;
        int n_frames;
        int last_k;
        for (int i = 0; i < 8; i++) send_bit(f1[i]);
        n_frames = (s0 >= 0) ? 2 : 1;
        last_k   = 64 * n_frames + 1;
        for (int k = 0; k <= last_k; k++) begin
            int fr, pos, bi, rel, j;
            int e_a, e_b, e_clk, e_busy, e_done;
            di_strobe = 1'b0;
            if (s0 >= 0) begin
                rel = k - s0;
                if (rel >= 0 && (rel % 2) == 0) begin
                    j = rel / 2;
                    if (j < 8) begin
                        di = f2[j];
                        di_strobe = 1'b1;
                    end else if (j < 8 + extra) begin
                        di = 1'b0;
                        di_strobe = 1'b1;
                    end
                end
            end
            fr  = k / 64;
            pos = k % 64;
            e_busy = (fr < n_frames) ? 1 : 0;
            e_done = (k > 0 && pos == 0 && fr <= n_frames) ? 1 : 0;
            if (fr < n_frames) begin
                fa    = (fr == 0) ? f1 : f2;
                bi    = pos / 8;
                e_a   = int'(fa[bi]);
                e_b   = int'(fa[7 - bi]);
                e_clk = ((pos % 8) >= 4) ? 1 : 0;
            end else begin
                e_a = 0; e_b = 0; e_clk = 0;
            end
            check($sformatf("%s do_a k=%0d", name, k), int'(do_a), e_a);
            check($sformatf("%s do_b k=%0d", name, k), int'(do_b), e_b);
            check($sformatf("%s clkimpr_a k=%0d", name, k), int'(clk_a), e_clk);
            check($sformatf("%s clkimpr_b k=%0d", name, k), int'(clk_b), e_clk);
            check($sformatf("%s busy_a k=%0d", name, k), int'(busy_a), e_busy);
            check($sformatf("%s busy_b k=%0d", name, k), int'(busy_b), e_busy);
            check($sformatf("%s done_a k=%0d", name, k), int'(done_a), e_done);
            check($sformatf("%s done_b k=%0d", name, k), int'(done_b), e_done);
            if (s0 >= 0) begin
                check($sformatf("%s pending k=%0d", name, k), int'(dut_a.pending_q),
                      (k >= s0 + 15 && k < 64) ? 1 : 0);
                check($sformatf("%s overflow_a k=%0d", name, k), int'(ovf_a),
                      (extra > 0 && k >= s0 + 17) ? 1 : 0);
                check($sformatf("%s overflow_b k=%0d", name, k), int'(ovf_b),
                      (extra > 0 && k >= s0 + 17) ? 1 : 0);
                if (k == 65) check($sformatf("%s count after transfer", name),
                                   int'(dut_a.count_q), 0);
            end else if (k == last_k) begin
                check($sformatf("%s overflow_a", name), int'(ovf_a), 0);
            end
            @(negedge clk);
        end
        di_strobe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Reset mid-frame, with DI_STROBE rising during reset and held high after it.
    task automatic run_reset_mid_frame();
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        for (int k = 0; k < 100; k++) begin
            if (k == 26) begin
                rst = 1'b1;
                di_strobe = 1'b1;
            end
            if (k == 27) rst = 1'b0;
            if (k == 35) di_strobe = 1'b0;
            if (k == 25) begin
                check("rst pre busy", int'(busy_a), 1);
                check("rst pre overflow sticky", int'(ovf_a), 1);
            end
            if (k == 27) begin
                check("rst do", int'(do_a), 0);
                check("rst clkimpr", int'(clk_a), 0);
                check("rst busy", int'(busy_a), 0);
                check("rst overflow", int'(ovf_a), 0);
                check("rst done", int'(done_a), 0);
            end
            if (k > 27) begin
                check($sformatf("rst no done k=%0d", k), int'(done_a), 0);
                check($sformatf("rst stays idle k=%0d", k), int'(busy_a), 0);
            end
            if (k == 40) check("rst held strobe not captured", int'(dut_a.count_q), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        di        = 1'b0;
        di_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("reset do", int'(do_a), 0);
        check("reset clkimpr", int'(clk_a), 0);
        check("reset busy", int'(busy_a), 0);
        check("reset done", int'(done_a), 0);
        check("reset overflow", int'(ovf_a), 0);
        check("reset count", int'(dut_a.count_q), 0);
        check("reset pending", int'(dut_a.pending_q), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame 1,0,1,1,0,0,1,0 (bit 0 collected first).
        run_frames(8'h4D, 8'h00, -1, 0, "basic");
        // Second frame 0xFF collected during the first transmission.
        run_frames(8'h4D, 8'hFF, 2, 0, "dbuf");
        // Eighth edge of the next frame coincides with frame_done.
        run_frames(8'h4D, 8'h8B, 49, 0, "simul");
        // Three edges while a frame is pending: dropped, overflow sticks.
        run_frames(8'h4D, 8'hFF, 2, 3, "ovf");
        run_reset_mid_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
